// File: rtl/data_memory_pkg.sv
// Shared types and default sizing for the DataMemory arbiter slice.
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_DEPTH      = 5;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester arbiter: round-robin on lastGrant, or fixed priority to A.
module rr_arbiter_2
  import data_memory_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic       i_req_a,
  input  logic       i_req_b,
  input  grant_t     i_last_grant,
  output logic [1:0] o_grant      // bit 0 = A, bit 1 = B
);

  always_comb begin
    // NOTE: default first so every path assigns o_grant and no latch is inferred.
    o_grant = 2'b00;
    if (PRIORITY_MODE != 0) begin
      if (i_req_a)      o_grant = 2'b01;
      else if (i_req_b) o_grant = 2'b10;
    end else if (i_req_a && i_req_b) begin
      // A tie goes to whoever was not served last.
      o_grant = (i_last_grant == GRANT_B) ? 2'b01 : 2'b10;
    end else if (i_req_a) begin
      o_grant = 2'b01;
    end else if (i_req_b) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port DataMemory between requesters A and B; every access
// runs IDLE -> ACCESS -> RESP, with out-of-range addresses blocked and flagged.
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  aValid,
  output logic                  aReady,
  input  logic                  aWrite,
  input  logic [ADDR_WIDTH-1:0] aAddress,
  input  logic [DATA_WIDTH-1:0] aWriteData,
  output logic                  aRespValid,
  output logic                  aRespError,
  output logic [DATA_WIDTH-1:0] aReadData,
  input  logic                  bValid,
  output logic                  bReady,
  input  logic                  bWrite,
  input  logic [ADDR_WIDTH-1:0] bAddress,
  input  logic [DATA_WIDTH-1:0] bWriteData,
  output logic                  bRespValid,
  output logic                  bRespError,
  output logic [DATA_WIDTH-1:0] bReadData,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(DEPTH);

  state_t                r_state;
  grant_t                r_last_grant;
  grant_t                r_grant;
  logic                  r_write;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [1:0]            w_grant;
  logic                  w_sel_b;
  logic                  w_accept;
  logic                  w_req_write;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [DATA_WIDTH-1:0] w_req_wdata;
  logic                  w_access_ok;

  rr_arbiter_2 #(
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_arb (
    .i_req_a      (aValid),
    .i_req_b      (bValid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Readies are held low while reset is asserted so every output reads 0.
  assign aReady      = resetN && (r_state == IDLE) && w_grant[0];
  assign bReady      = resetN && (r_state == IDLE) && w_grant[1];
  assign w_accept    = aReady || bReady;
  assign w_sel_b     = w_grant[1];
  assign w_req_write = w_sel_b ? bWrite     : aWrite;
  assign w_req_addr  = w_sel_b ? bAddress   : aAddress;
  assign w_req_wdata = w_sel_b ? bWriteData : aWriteData;

  always_ff @(posedge clock or negedge resetN) begin
    // NOTE: non-blocking assignments for all state so every register updates from pre-edge values.
    if (!resetN) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_B;
      r_grant      <= GRANT_A;
      r_write      <= 1'b0;
      r_error      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_grant      <= w_sel_b ? GRANT_B : GRANT_A;
            r_last_grant <= w_sel_b ? GRANT_B : GRANT_A;
            r_write      <= w_req_write;
            r_addr       <= w_req_addr;
            r_wdata      <= w_req_wdata;
            r_error      <= (w_req_addr >= LP_DEPTH);
            r_rdata      <= '0;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_error && !r_write) r_rdata <= memReadData;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory pins are decoded from the registered state, so an async reset
  // mid-ACCESS removes memWrite before the committing edge.
  assign w_access_ok  = (r_state == ACCESS) && !r_error;
  assign memRead      = w_access_ok && !r_write;
  assign memWrite     = w_access_ok && r_write;
  assign memAddress   = w_access_ok ? r_addr : '0;
  assign memWriteData = (w_access_ok && r_write) ? r_wdata : '0;

  assign aRespValid = (r_state == RESP) && (r_grant == GRANT_A);
  assign bRespValid = (r_state == RESP) && (r_grant == GRANT_B);
  assign aRespError = aRespValid && r_error;
  assign bRespError = bRespValid && r_error;
  assign aReadData  = (aRespValid && !r_write) ? r_rdata : '0;
  assign bReadData  = (bRespValid && !r_write) ? r_rdata : '0;

endmodule
